mem_access_unit: RTL and testbench

//   Initiator side of the data-memory port. Accepts one load/store request at a time from the
//   MEM stage and drives the word-addressed, byte-enabled data memory: dm_we, dm_be, dm_addr, dm_wd.
//   For loads, it extracts the addressed byte or halfword from the returned word and sign- or

---
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - data-memory initiator: one load/store at a time, legality check, load extension
module mem_access_unit #(
    parameter int DM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    input  logic [31:0] dm_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] OP_LW  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LHU = 4'b0010;
    localparam logic [3:0] OP_LB  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SB  = 4'b1010;

    // 33 bits so the limit cannot wrap for large memories
    localparam logic [32:0] ADDR_LIMIT = 33'(DM_WORDS) << 2;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;

    logic        req_legal;
    logic        aligned;
    logic [3:0]  store_be;
    logic [31:0] load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        aligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW:          aligned = (req_addr[1:0] == 2'b00);
            OP_LH, OP_LHU, OP_SH:  aligned = (req_addr[0] == 1'b0);
            OP_LB, OP_LBU, OP_SB:  aligned = 1'b1;
            default:               aligned = 1'b0;
        endcase
        req_legal = aligned && ({1'b0, req_addr} < ADDR_LIMIT);
    end

    always_comb begin
        byte_sel  = dm_rd[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = dm_rd[{addr_q[1], 4'b0000} +: 16];
        load_data = 32'h0;
        store_be  = 4'b0000;
        case (op_q)
            OP_LW:   load_data = dm_rd;
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0, half_sel};
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h0, byte_sel};
            OP_SW:   store_be  = 4'b1111;
            OP_SH:   store_be  = addr_q[1] ? 4'b1100 : 4'b0011;
            OP_SB:   store_be  = 4'b0001 << addr_q[1:0];
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        dm_we       = 1'b0;
        dm_be       = 4'b0000;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d        = req_op;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    resp_data_d = 32'h0;
                    resp_err_d  = !req_legal;
                    state_d     = req_legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                // Reset gating keeps a store caught by reset from reaching memory
                dm_we       = op_q[3] && !reset;
                dm_be       = store_be;
                resp_data_d = load_data;
                state_d     = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 4'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign dm_addr   = {addr_q[31:2], 2'b00};
    assign dm_wd     = wdata_q;
    assign resp_data = resp_data_q;
    assign resp_err  = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized bench for mem_access_unit against a byte-level memory model
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem   [0:4095];
    logic [7:0]  ref_b [0:16383];

    always #5 clk = ~clk;

    mem_access_unit #(.DM_WORDS(4096)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_rd(dm_rd)
    );

    assign dm_rd = mem[dm_addr[13:2]];

    // Memory places low-aligned write data into whichever lanes are enabled
    always @(posedge clk) begin
        if (dm_we) begin
            case (dm_be)
                4'b1111: mem[dm_addr[13:2]]        <= dm_wd;
                4'b0011: mem[dm_addr[13:2]][15:0]  <= dm_wd[15:0];
                4'b1100: mem[dm_addr[13:2]][31:16] <= dm_wd[15:0];
                4'b0001: mem[dm_addr[13:2]][7:0]   <= dm_wd[7:0];
                4'b0010: mem[dm_addr[13:2]][15:8]  <= dm_wd[7:0];
                4'b0100: mem[dm_addr[13:2]][23:16] <= dm_wd[7:0];
                4'b1000: mem[dm_addr[13:2]][31:24] <= dm_wd[7:0];
                default: ;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int access_size(input logic [3:0] op);
        case (op)
            4'd0, 4'd8:        return 4;
            4'd1, 4'd2, 4'd9:  return 2;
            4'd3, 4'd4, 4'd10: return 1;
            default:           return 0;
        endcase
    endfunction

    task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input int hold, output logic [31:0] got);
        int          sz;
        bit          legal, is_store;
        logic [31:0] exp_data, exp_be, held;
        sz       = access_size(op);
        is_store = op[3];
        legal    = (sz != 0) && (addr % sz == 0) && (addr < 32'h4000);
        exp_data = 0;
        exp_be   = 0;
        if (legal) begin
            exp_be = ((1 << sz) - 1) << (addr % 4);
            if (!is_store) begin
                for (int i = 0; i < sz; i++) exp_data |= 32'(ref_b[addr + i]) << (8 * i);
                if (op == 4'd3 && exp_data[7])  exp_data |= 32'hFFFF_FF00;
                if (op == 4'd1 && exp_data[15]) exp_data |= 32'hFFFF_0000;
            end
        end

        check_eq("req_ready_idle", req_ready, 1);
        req_valid = 1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 0; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;

        if (legal) begin
            check_eq("acc_resp_valid", resp_valid, 0);
            check_eq("acc_dm_we", dm_we, is_store);
            check_eq("acc_dm_be", dm_be, is_store ? exp_be : 0);
            check_eq("acc_dm_addr", dm_addr, addr & 32'hFFFF_FFFC);
            if (is_store) check_eq("acc_dm_wd", dm_wd, wdata);
            @(posedge clk); #1;
        end else begin
            check_eq("err_dm_we", dm_we, 0);
            if (!resp_valid) begin
                @(posedge clk); #1;
                check_eq("err_dm_we2", dm_we, 0);
            end
        end
        check_eq("resp_valid", resp_valid, 1);
        check_eq("resp_data", resp_data, exp_data);
        check_eq("resp_err", resp_err, !legal);
        got  = resp_data;
        held = resp_data;

        for (int k = 0; k < hold; k++) begin
            req_valid = 1;
            @(posedge clk); #1;
            check_eq("hold_valid", resp_valid, 1);
            check_eq("hold_data", resp_data, held);
            check_eq("hold_err", resp_err, !legal);
            check_eq("hold_req_ready", req_ready, 0);
            check_eq("hold_dm_we", dm_we, 0);
        end
        req_valid  = 0;
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        check_eq("after_resp_valid", resp_valid, 0);

        if (legal && is_store)
            for (int i = 0; i < sz; i++) ref_b[addr + i] = wdata[8*i +: 8];
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 1);
        check_eq({tag, "_resp_valid"}, resp_valid, 0);
        check_eq({tag, "_resp_data"}, resp_data, 0);
        check_eq({tag, "_resp_err"}, resp_err, 0);
        check_eq({tag, "_dm_we"}, dm_we, 0);
        check_eq({tag, "_dm_be"}, dm_be, 0);
        check_eq({tag, "_dm_addr"}, dm_addr, 0);
        check_eq({tag, "_dm_wd"}, dm_wd, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [3:0]  legal_ops [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10};

        for (int i = 0; i < 4096; i++)  mem[i] = 32'h0;
        for (int i = 0; i < 16384; i++) ref_b[i] = 8'h0;
        reset = 1; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        check_reset_outputs("rst");

        run_req(4'd8, 32'h10, 32'hDEADBEEF, 0, got);
        run_req(4'd0, 32'h10, 32'h0, 0, got);
        check_eq("t1_lw", got, 32'hDEADBEEF);
        run_req(4'd10, 32'h13, 32'h0000_00F0, 1, got);
        run_req(4'd3, 32'h13, 32'h0, 0, got);
        check_eq("t2_lb", got, 32'hFFFF_FFF0);
        run_req(4'd4, 32'h13, 32'h0, 0, got);
        check_eq("t2_lbu", got, 32'h0000_00F0);
        run_req(4'd0, 32'h10, 32'h0, 0, got);
        check_eq("t2_lw", got, 32'hF0AD_BEEF);
        run_req(4'd9, 32'h22, 32'h0000_8001, 0, got);
        run_req(4'd1, 32'h22, 32'h0, 0, got);
        check_eq("t3_lh", got, 32'hFFFF_8001);
        run_req(4'd2, 32'h22, 32'h0, 0, got);
        check_eq("t3_lhu", got, 32'h0000_8001);
        run_req(4'd8, 32'h11, 32'h1234_5678, 2, got);
        run_req(4'd1, 32'h21, 32'h0, 0, got);
        run_req(4'd7, 32'h00, 32'h0, 0, got);
        run_req(4'd0, 32'h4000, 32'h0, 0, got);
        run_req(4'd0, 32'h10, 32'h0, 5, got);
        check_eq("t5_lw_after_hold", got, 32'hF0AD_BEEF);

        // Reset landing on a store's ACCESS cycle must suppress the write
        run_req(4'd8, 32'h40, 32'h1111_1111, 0, got);
        req_valid = 1; req_op = 4'd8; req_addr = 32'h40; req_wdata = 32'h2222_2222;
        @(posedge clk); #1;
        req_valid = 0;
        check_eq("t6_acc_we", dm_we, 1);
        reset = 1;
        #1;
        check_eq("t6_we_gated", dm_we, 0);
        @(posedge clk); #1;
        reset = 0;
        check_reset_outputs("t6");
        run_req(4'd0, 32'h40, 32'h0, 0, got);
        check_eq("t6_lw_prior", got, 32'h1111_1111);

        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 9))
                0:       addr = 32'h4000 + $urandom_range(0, 255);
                1:       addr = $urandom;
                default: addr = $urandom_range(0, 63);
            endcase
            run_req(op, addr, $urandom, $urandom_range(0, 3), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
